shift_add_mult: RTL and testbench

Sequential unsigned shift-and-add multiplier, the multiply counterpart of the restoring divider's datapath. The divider shifts the {A,Q} register pair left each iteration; this block adds the multiplicand conditionally into the {C,A} accumulator and shifts {C,A,Q} right each iteration. It takes one WIDTH-bit × WIDTH-bit operand pair per start pulse and produces a 2·WIDTH-bit product after WIDTH iteration cycles. It sits beside the divider in the arithmetic unit and uses the same start/done handshake style.

---
 rtl/shift_add_mult_pkg.sv | 23 ++
 rtl/shift_add_mult_rshift.sv | 29 ++
 rtl/shift_add_mult.sv | 116 +++++++++++
 tb/tb_shift_add_mult.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier and its
// companion restoring divider: FSM state encoding, default operand width and
// the iteration-counter width helper.
// -----------------------------------------------------------------------------
package shift_add_mult_pkg;

  // Operand width used when a parent does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Two-state control FSM shared by the multiply and divide datapaths.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The iteration counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : shift_add_mult_pkg

// File: rtl/shift_add_mult_rshift.sv
// -----------------------------------------------------------------------------
// shift_add_mult_rshift
// Combinational right-shift stage of the multiplier: {out_a, out_q} is the
// concatenation {sum, q} shifted right by one. The bit that lands above out_a
// (the old carry position) is always zero and is not produced.
//
// Ports:
//   i_sum  [WIDTH:0]   accumulator sum including its carry bit
//   i_q    [WIDTH-1:0] current multiplier/low-product register
//   o_a    [WIDTH-1:0] next A register value (sum[WIDTH:1])
//   o_q    [WIDTH-1:0] next Q register value ({sum[0], q[WIDTH-1:1]})
// -----------------------------------------------------------------------------
module shift_add_mult_rshift #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_sum,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_q
);

  // q[0] has already been consumed as the add-enable, so it falls off the end.
  logic w_unused_q0;

  assign w_unused_q0 = i_q[0];
  assign o_a         = i_sum[WIDTH:1];
  assign o_q         = {i_sum[0], i_q[WIDTH-1:1]};

endmodule : shift_add_mult_rshift

// File: rtl/shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
// Sequential unsigned shift-and-add multiplier. One WIDTH x WIDTH operand pair
// is accepted per start pulse while idle; WIDTH iteration cycles later the
// 2*WIDTH-bit product is final and done pulses for one cycle. The product is
// held until the next accepted start.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset (priority over start)
//   i_start         operation request, sampled only while idle
//   i_multiplicand  M operand, captured on an accepted start
//   i_multiplier    Q operand, captured on an accepted start
//   o_busy          high while iterating
//   o_done          one-cycle pulse: product is final
//   o_product       {A,Q} register pair
// -----------------------------------------------------------------------------
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = count_width(WIDTH);

  state_t           r_state;
  logic             r_c;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;
  logic             r_done;

  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_q;

  // Conditional add: M joins the {C,A} accumulator when the current multiplier LSB is set.
  always_comb begin
    w_acc = {r_c, r_a};
    if (r_q[0]) begin
      w_sum = w_acc + {1'b0, r_m};
    end else begin
      w_sum = w_acc;
    end
  end

  shift_add_mult_rshift #(
    .WIDTH (WIDTH)
  ) u_rshift (
    .i_sum (w_sum),
    .i_q   (r_q),
    .o_a   (w_next_a),
    .o_q   (w_next_q)
  );

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_c     <= 1'b0;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_m     <= i_multiplicand;
            r_q     <= i_multiplier;
            r_a     <= '0;
            r_c     <= 1'b0;
            r_count <= CW'(WIDTH);
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // The shift brings a zero into C; any carry has moved into A's MSB.
          r_c     <= 1'b0;
          r_a     <= w_next_a;
          r_q     <= w_next_q;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = (r_state == RUN);
  assign o_done    = r_done;
  assign o_product = {r_a, r_q};

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult
// Directed self-checking bench for shift_add_mult (WIDTH=8). Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] prod;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  shift_add_mult #(
    .WIDTH (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (prod)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete multiply: latency, product, and hold after done.
  task automatic mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_prod"}, prod, exp);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_hold"}, prod, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ndone;
    int k1;
    int k2;
    logic [15:0] p1;
    logic [15:0] p2;

    rst    = 1'b1;
    start  = 1'b0;
    mcand  = 8'h00;
    mplier = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", prod, 0);
    rst = 1'b0;

    // 13 x 11 with cycle-exact busy/done timing.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h0D;
    mplier = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t13_busy_c%0d", k), busy, 1);
      check($sformatf("t13_done_c%0d", k), done, 0);
      @(negedge clk);
    end
    check("t13_done", done, 1);
    check("t13_busy_end", busy, 0);
    check("t13_prod", prod, 16'h008F);
    @(negedge clk);
    check("t13_done_low", done, 0);
    check("t13_hold", prod, 16'h008F);

    mul("ffxff", 8'hFF, 8'hFF, 16'hFE01);
    mul("0fx0f", 8'h0F, 8'h0F, 16'h00E1);
    mul("0xa5", 8'h00, 8'hA5, 16'h0000);
    mul("a5x0", 8'hA5, 8'h00, 16'h0000);

    // Restart attempt while busy must be ignored.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h12;
    mplier = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h77;
    mplier = 8'h99;
    check("restart_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    p1    = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        ndone++;
        p1 = prod;
      end
      @(negedge clk);
    end
    check("restart_ndone", ndone, 1);
    check("restart_prod", p1, 16'h03A8);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'hAA;
    mplier = 8'hBB;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_prod", prod, 0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_nodone", ndone, 0);
    mul("post_rst", 8'h11, 8'h10, 16'h0110);

    // start held high: second op accepted in the first op's done cycle.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h02;
    mplier = 8'h03;
    @(negedge clk);
    mcand  = 8'h04;
    mplier = 8'h05;
    ndone  = 0;
    k1     = 0;
    k2     = 0;
    p1     = 16'h0000;
    p2     = 16'h0000;
    for (int k = 1; k <= 30 && ndone < 2; k++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          k1 = k;
          p1 = prod;
        end else begin
          k2    = k;
          p2    = prod;
          start = 1'b0;
        end
      end
      if (ndone < 2) @(negedge clk);
    end
    check("b2b_ndone", ndone, 2);
    check("b2b_prod1", p1, 16'h0006);
    check("b2b_prod2", p2, 16'h0014);
    check("b2b_first_lat", k1, 9);
    check("b2b_gap", k2 - k1, 9);
    @(negedge clk);
    check("b2b_idle", busy, 0);
    check("b2b_hold", prod, 16'h0014);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_shift_add_mult
